// File: rtl/frequency_meter_if.sv
// Result channel of frequency_meter: measured values plus valid/ack handshake.
// master (meter) drives period, highTime, valid, overrun, overflow; slave drives ack.
interface frequency_meter_if #(
  parameter int CNT_W = 16
);
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] highTime;
  logic             valid;
  logic             ack;
  logic             overrun;
  logic             overflow;

  modport master (
    output period, highTime, valid, overrun, overflow,
    input  ack
  );

  modport slave (
    input  period, highTime, valid, overrun, overflow,
    output ack
  );
endinterface

// File: rtl/frequency_meter.sv
// Measures period and high time of slow async sigIn in clk cycles; results on res.
// Ports: clk, rstN (async low), sigIn, clear (sync restart), res (master). Macro: FREQ_METER_AVG_EN.
module frequency_meter #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               sigIn,
  input  logic               clear,
  frequency_meter_if.master  res
);

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t           state;
  logic             s1;
  logic             s2;
  logic             s3;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hiCap;
  logic [CNT_W-1:0] perV;
  logic [CNT_W-1:0] hiV;
  logic             rise;
  logic             fall;
  logic             tmo;
  logic             cap;

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  assign tmo  = (state == MEASURE) && !rise && (cnt == MAX);

  // sync flops are deliberately left out of clear
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sigIn;
      s2 <= s1;
      s3 <= s2;
    end
  end

`ifdef FREQ_METER_AVG_EN
  logic [CNT_W+1:0] sum;
  logic [CNT_W+1:0] hiSum;
  logic [CNT_W+1:0] sumNxt;
  logic [CNT_W+1:0] hiNxt;
  logic [1:0]       idx;

  assign sumNxt = sum + {2'b00, cnt};
  assign hiNxt  = hiSum + {2'b00, hiCap};
  assign cap    = (state == MEASURE) && rise && (idx == 2'd3);
  assign perV   = CNT_W'(sumNxt >> 2);
  assign hiV    = CNT_W'(hiNxt >> 2);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sum   <= '0;
      hiSum <= '0;
      idx   <= 2'd0;
    end else if (clear || tmo) begin
      sum   <= '0;
      hiSum <= '0;
      idx   <= 2'd0;
    end else if ((state == MEASURE) && rise) begin
      idx <= idx + 2'd1;
      if (idx == 2'd3) begin
        sum   <= '0;
        hiSum <= '0;
      end else begin
        sum   <= sumNxt;
        hiSum <= hiNxt;
      end
    end
  end
`else
  assign cap  = (state == MEASURE) && rise;
  assign perV = cnt;
  assign hiV  = hiCap;
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state        <= IDLE;
      cnt          <= '0;
      hiCap        <= '0;
      res.period   <= '0;
      res.highTime <= '0;
      res.valid    <= 1'b0;
      res.overrun  <= 1'b0;
      res.overflow <= 1'b0;
    end else if (clear) begin
      state        <= IDLE;
      cnt          <= '0;
      hiCap        <= '0;
      res.period   <= '0;
      res.highTime <= '0;
      res.valid    <= 1'b0;
      res.overrun  <= 1'b0;
      res.overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rise) begin
            state <= MEASURE;
            cnt   <= ONE;
          end
        end
        MEASURE: begin
          if (rise) begin
            cnt <= ONE;
          end else if (cnt == MAX) begin
            state        <= IDLE;
            cnt          <= '0;
            res.overflow <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
      endcase

      if ((state == MEASURE) && fall) begin
        hiCap <= cnt;
      end

      // a capture always wins over ack; overrun only when old result unacked
      if (cap) begin
        res.period   <= perV;
        res.highTime <= hiV;
        res.valid    <= 1'b1;
        if (res.valid && !res.ack) begin
          res.overrun <= 1'b1;
        end
      end else if (res.valid && res.ack) begin
        res.valid <= 1'b0;
      end
    end
  end

endmodule
